adder_csa_pipe: RTL and testbench
=================================

Name: adder_csa_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor.
- Successor to the fixed 32-bit carry-select adder; generalises width, block size and pipeline depth, and adds a subtract mode.
- Uses a valid/ready handshake, so it sits directly on ALU and datapath streams that can stall.
- The carry chain is cut into STAGES register stages, so fmax holds as WIDTH grows.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of BLK.
- BLK, 4, carry-select block width in bits.
- STAGES, 2, number of pipeline register stages (1..NB); NB = WIDTH/BLK must be a multiple of STAGES.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts the input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry in; ignored when sub=1.
- sub  in  1  0: a+b+ci; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum or difference.
- co  out  1  carry out; for subtract, co=1 means no borrow.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage structure:
  - Stage k (k=0..STAGES-1) resolves blocks [k*NB/STAGES, (k+1)*NB/STAGES).
  - Within a group, block 0 is ripple/CLA on the incoming carry.
  - Every other block in the group precomputes sum and carry for carry-in 0 and carry-in 1, then muxes on the previous block's carry.
- Each stage register holds:
  - valid bit;
  - low sum bits resolved so far;
  - high operand bits not yet consumed, with b already inverted when sub=1;
  - carry into the next group.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: 1 result per cycle.
- Handshake:
  - Stage k loads when its register is empty or when it is advancing into stage k+1.
  - Last stage advances on out_ready.
  - in_ready = !v[0] || advance[0]. It is combinational from out_ready through the valid chain; no path from in_valid to in_ready.
  - Stage bubbles collapse: a stall downstream fills empty upstream stages before in_ready drops.
  - Holding: s, co and out_valid stay stable while out_valid && !out_ready. Inputs need not be held after a transfer.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - co is the carry out of bit WIDTH-1.
  - sub=1 forces the effective carry-in to 1 and inverts b before stage 0 registers.
- Reset:
  - rst_n low clears all valid bits immediately (asynchronously).
  - Output reset values: out_valid=0, s=0, co=0, in_ready=1.
  - Data registers also reset to 0.
  - In-flight results are discarded.
  - Reset deassertion is expected synchronous to clk; first accept possible in the first cycle after deassertion.
- STAGES=1 degenerates to a single output register (latency 1).
- Illegal parameter combinations are stopped by an elaboration-time check that raises a fatal error.

Optional Feature:
- Macro: ADDER_CSA_FLAGS_EN.
- Defined: adds output ports zf (1, s==0), nf (1, s[WIDTH-1]) and vf (1, signed overflow).
  - vf is computed as the carry into MSB xor co.
  - Flags are registered alongside the last stage, follow the same valid/hold rules, and reset to 0.
- Undefined: ports absent; no flag logic generated.

Decomposition:
- Package adder_pkg:
  - default constants ADDER_WIDTH=32, ADDER_BLK=4, ADDER_STAGES=2;
  - function to compute NB and blocks-per-stage;
  - typedef for the per-stage payload struct.
- Sub-module csa_block (parametrised BLK):
  - combinational dual-carry block: inputs a, b, ci; outputs s, co;
  - distinct from the existing fixed-width block;
  - instantiated NB times via generate.

Test Plan:
- WIDTH=32, STAGES=2: a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0, out_ready=1 -> out_valid after 2 cycles, s=0x00000000, co=1 (carry ripples across the stage cut).
- sub=1, a=5, b=7 -> s=0xFFFFFFFE, co=0. sub=1, a=7, b=5, ci=1 -> s=2, co=1 (ci ignored).
- Back-to-back stream of 16 random pairs with out_ready toggling 1010...:
  - every result matches the reference model in order;
  - none lost or duplicated;
  - s/co stable while stalled.
- out_ready=0 held with continuous in_valid:
  - exactly STAGES inputs accepted, then in_ready=0;
  - releasing out_ready resumes 1 per cycle.
- Reset mid-stream with 2 results in flight:
  - out_valid=0, s=0 immediately on rst_n low;
  - after release, the first new input emerges after STAGES cycles with no stale data.
- With ADDER_CSA_FLAGS_EN, a=0x7FFFFFFF, b=1 -> s=0x80000000, vf=1, nf=1, zf=0. Also WIDTH=64, BLK=8, STAGES=4 regression of the same vectors, zero-extended.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, sizing helpers and stage control payload for the pipelined carry-select adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_BLK    = 4;
  localparam int unsigned ADDER_STAGES = 2;

  // Control part of a stage register; the data fields are WIDTH-dependent and live in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned calc_nb(int unsigned width, int unsigned blk);
    return (blk == 0) ? 0 : width / blk;
  endfunction

  function automatic int unsigned calc_bps(int unsigned width, int unsigned blk,
                                           int unsigned stages);
    return (stages == 0) ? 0 : calc_nb(width, blk) / stages;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational carry-select block: sums for carry-in 0 and 1 are formed in parallel,
// the real carry-in only drives the final mux.
module csa_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] w_sum0;
  logic [BLK:0] w_sum1;

  assign w_sum0  = {1'b0, a} + {1'b0, b};
  assign w_sum1  = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  assign {co, s} = ci ? w_sum1 : w_sum0;

endmodule

// File: rtl/adder_csa_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake, STAGES carry-chain cuts.
// Define ADDER_CSA_FLAGS_EN to add registered zf/nf/vf flag outputs.
module adder_csa_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDER_WIDTH,
  parameter int unsigned BLK    = ADDER_BLK,
  parameter int unsigned STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADDER_CSA_FLAGS_EN
  ,
  output logic             zf,
  output logic             nf,
  output logic             vf
`endif
);

  localparam int unsigned NB  = calc_nb(WIDTH, BLK);
  localparam int unsigned BPS = calc_bps(WIDTH, BLK, STAGES);
  localparam int unsigned GW  = BPS * BLK;

  if (BLK == 0 || STAGES == 0 || (WIDTH % BLK) != 0 || STAGES > NB || (NB % STAGES) != 0)
  begin : g_param_check
    $fatal(1, "adder_csa_pipe: illegal WIDTH/BLK/STAGES combination");
  end

  stage_ctl_t        r_ctl   [STAGES];
  logic [WIDTH-1:0]  r_s     [STAGES];
  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];

  logic [WIDTH-1:0]  w_src_a [STAGES];
  logic [WIDTH-1:0]  w_src_b [STAGES];
  logic [WIDTH-1:0]  w_src_s [STAGES];
  logic [WIDTH-1:0]  w_nxt_s [STAGES];
  logic [STAGES-1:0] w_src_c;
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_nxt_c;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_blk_s;
  logic              w_nxt_ld;

  // Each stage sees either the raw inputs or the previous stage register.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - GW)) << (k * GW);
    if (k == 0) begin : g_in
      assign w_src_a[k] = a;
      assign w_src_b[k] = sub ? ~b : b;
      assign w_src_c[k] = sub | ci;
      assign w_src_v[k] = in_valid;
      assign w_src_s[k] = '0;
    end else begin : g_prev
      assign w_src_a[k] = r_a[k-1];
      assign w_src_b[k] = r_b[k-1];
      assign w_src_c[k] = r_ctl[k-1].carry;
      assign w_src_v[k] = r_ctl[k-1].valid;
      assign w_src_s[k] = r_s[k-1];
    end
    assign w_nxt_s[k] = (w_src_s[k] & ~MASK) | (w_blk_s & MASK);
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    localparam int unsigned K = j / BPS;
    logic w_ci;
    logic w_co;
    if ((j % BPS) == 0) begin : g_first
      assign w_ci = w_src_c[K];
    end else begin : g_chain
      assign w_ci = g_blk[j-1].w_co;
    end
    csa_block #(.BLK(BLK)) u_csa (
      .a  (w_src_a[K][j*BLK +: BLK]),
      .b  (w_src_b[K][j*BLK +: BLK]),
      .ci (w_ci),
      .s  (w_blk_s[j*BLK +: BLK]),
      .co (w_co)
    );
    if ((j % BPS) == BPS - 1) begin : g_group_co
      assign w_nxt_c[K] = w_co;
    end
  end

  // Walk from the output back: a stage may load if empty or if its content moves on.
  always_comb begin
    w_load   = '0;
    w_nxt_ld = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = !r_ctl[k].valid || w_nxt_ld;
      w_nxt_ld  = w_load[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctl[k] <= '0;
        r_s[k]   <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_ctl[k].valid <= w_src_v[k];
          if (w_src_v[k]) begin
            r_ctl[k].carry <= w_nxt_c[k];
            r_s[k]         <= w_nxt_s[k];
            r_a[k]         <= w_src_a[k];
            r_b[k]         <= w_src_b[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_ctl[STAGES-1].valid;
  assign s         = r_s[STAGES-1];
  assign co        = r_ctl[STAGES-1].carry;

`ifdef ADDER_CSA_FLAGS_EN
  logic r_zf;
  logic r_nf;
  logic r_vf;
  logic w_msb_ci;

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign w_msb_ci = w_blk_s[WIDTH-1] ^ w_src_a[STAGES-1][WIDTH-1] ^ w_src_b[STAGES-1][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b0;
      r_nf <= 1'b0;
      r_vf <= 1'b0;
    end else if (w_load[STAGES-1] && w_src_v[STAGES-1]) begin
      r_zf <= (w_nxt_s[STAGES-1] == '0);
      r_nf <= w_nxt_s[STAGES-1][WIDTH-1];
      r_vf <= w_msb_ci ^ w_nxt_c[STAGES-1];
    end
  end

  assign zf = r_zf;
  assign nf = r_nf;
  assign vf = r_vf;
`endif

endmodule

// File: tb/tb_adder_csa_pipe.sv
// Directed self-checking bench for adder_csa_pipe (WIDTH=32, BLK=4, STAGES=2); flag checks
// are compiled in when ADDER_CSA_FLAGS_EN is defined.
module tb_adder_csa_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned BK = 4;
  localparam int unsigned ST = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
`ifdef ADDER_CSA_FLAGS_EN
  logic         zf;
  logic         nf;
  logic         vf;
`endif

  always #5 clk = ~clk;

  adder_csa_pipe #(.WIDTH(W), .BLK(BK), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef ADDER_CSA_FLAGS_EN
    ,
    .zf        (zf),
    .nf        (nf),
    .vf        (vf)
`endif
  );

  int         total = 0;
  int         bad   = 0;
  int         n_out = 0;
  logic [W:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // One clock: record transfers at the settled pre-edge values, then land 1 unit after the edge.
  task automatic tick(output logic acc);
    logic       stall;
    logic [W:0] held;
    logic [W:0] exp;
    #1;
    acc   = in_valid && in_ready;
    stall = out_valid && !out_ready;
    held  = {co, s};
    if (acc) q.push_back(ref_add(a, b, ci, sub));
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
      else begin
        exp = q.pop_front();
        check("result", 64'({co, s}), 64'(exp));
      end
    end
    @(posedge clk);
    #1;
    if (stall) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'({co, s}), 64'(held));
    end
  endtask

  task automatic drain();
    logic acc;
    int   guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && guard < 20) begin
      tick(acc);
      guard++;
    end
    check("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic sb, input logic [W-1:0] exp_s, input logic exp_co,
                         input string tag);
    logic acc;
    a = x; b = y; ci = c; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    check({tag, "_accept"}, 64'(acc), 64'(1));
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    tick(acc);
    check({tag, "_lat2"}, 64'(out_valid), 64'(1));
    check({tag, "_s"}, 64'(s), 64'(exp_s));
    check({tag, "_co"}, 64'(co), 64'(exp_co));
  endtask

  initial begin
    logic         acc;
    int           n_acc;
    int           o0;
    int           idx;
    int           cyc;
    logic [W-1:0] va [16];
    logic [W-1:0] vb [16];
    logic         vci [16];
    logic         vsub [16];

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_s", 64'(s), 64'(0));
    check("rst_co", 64'(co), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "carry_cut");
`ifdef ADDER_CSA_FLAGS_EN
    check("zero_zf", 64'(zf), 64'(1));
    check("zero_nf", 64'(nf), 64'(0));
    check("zero_vf", 64'(vf), 64'(0));
`endif
    drain();
    run_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
    drain();
    run_one(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, "sub_ci_ignored");
    drain();
    run_one(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, "add_ci");
    drain();
    run_one(32'h1234_5678, 32'h0000_0F0F, 1'b0, 1'b0, 32'h1234_6587, 1'b0, "add_plain");
    drain();

    // Back-to-back stream with out_ready toggling 1,0,1,0...
    for (int i = 0; i < 16; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vci[i] = 1'($urandom); vsub[i] = 1'($urandom);
    end
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vci[0] = 1'b1; vsub[0] = 1'b0;
    idx = 0; cyc = 0; o0 = n_out;
    while ((idx < 16 || q.size() > 0) && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      if (idx < 16) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; ci = vci[idx]; sub = vsub[idx];
      end else in_valid = 1'b0;
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    check("stream_count", 64'(n_out - o0), 64'(16));
    check("stream_drained", 64'(q.size()), 64'(0));
    drain();

    // Full backpressure with continuous input.
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    repeat (6) begin
      a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      tick(acc);
      n_acc += int'(acc);
    end
    check("bp_accepted", 64'(n_acc), 64'(ST));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(in_ready), 64'(1));
    n_acc = 0; o0 = n_out;
    repeat (4) begin
      a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      tick(acc);
      n_acc += int'(acc);
    end
    check("bp_resume_in", 64'(n_acc), 64'(4));
    check("bp_resume_out", 64'(n_out - o0), 64'(4));
    drain();

    // Reset with two results in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; ci = 1'b0; sub = 1'b0;
    tick(acc);
    a = 32'h0000_00FF; b = 32'h0000_0001;
    tick(acc);
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_s", 64'(s), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, "post_rst");
    drain();

`ifdef ADDER_CSA_FLAGS_EN
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, "ovf");
    check("ovf_vf", 64'(vf), 64'(1));
    check("ovf_nf", 64'(nf), 64'(1));
    check("ovf_zf", 64'(zf), 64'(0));
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
